// File: rtl/sat_mult_pkg.sv
// Shared types and constants for the saturating fixed-point multiplier datapaths.
package sat_mult_pkg;

  typedef enum logic [1:0] {
    RND_FLOOR      = 2'd0,
    RND_NEAREST    = 2'd1,
    RND_CONVERGENT = 2'd2
  } round_mode_e;

  localparam int unsigned PIPE_STAGES_MIN = 1;
  localparam int unsigned PIPE_STAGES_MAX = 3;

endpackage

// File: rtl/sat_mult_pipe_if.sv
// Sample-in / result-out bundle between a producer and the saturating multiplier.
interface sat_mult_pipe_if #(
  parameter int A_W   = 36,
  parameter int B_W   = 15,
  parameter int OUT_W = 39,
  parameter int CH_W  = 2
);
  logic                    in_valid;
  logic signed [A_W-1:0]   in_a;
  logic signed [B_W-1:0]   in_b;
  logic [CH_W-1:0]         in_ch;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_sat;

  modport master (
    output in_valid, in_a, in_b, in_ch,
    input  out_valid, out_data, out_ch, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ch,
    output out_valid, out_data, out_ch, out_sat
  );
endinterface

// File: rtl/sat_round.sv
// Combinational shift, round and saturate of a wide signed product into OUT_W bits.
module sat_round
  import sat_mult_pkg::*;
#(
  parameter int IN_W       = 51,
  parameter int SH         = 9,
  parameter int OUT_W      = 39,
  parameter int ROUND_MODE = 1
) (
  input  logic signed [IN_W-1:0]  prod,
  output logic signed [OUT_W-1:0] result,
  output logic                    sat
);
  localparam int TW = IN_W - SH;
  // One guard bit above the wider of T and OUT so the increment can never wrap.
  localparam int RW = ((TW > OUT_W) ? TW : OUT_W) + 1;
  localparam round_mode_e MODE = round_mode_e'(ROUND_MODE[1:0]);

  if (SH < 0 || SH >= IN_W) begin : g_bad_sh
    $error("sat_round: SH must lie in 0..IN_W-1");
  end
  if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_mode
    $error("sat_round: ROUND_MODE must be 0, 1 or 2");
  end

  logic signed [TW-1:0] t;
  logic                 inc;
  logic signed [RW-1:0] r;

  assign t = prod[IN_W-1:SH];

  if (SH == 0 || MODE == RND_FLOOR) begin : g_floor
    assign inc = 1'b0;
  end else if (MODE == RND_NEAREST) begin : g_nearest
    assign inc = prod[SH-1];
  end else if (SH == 1) begin : g_conv_sh1
    assign inc = prod[0] & t[0];
  end else begin : g_conv
    assign inc = prod[SH-1] & ((|prod[SH-2:0]) | t[0]);
  end

  assign r = {{(RW-TW){t[TW-1]}}, t} + {{(RW-1){1'b0}}, inc};

  always_comb begin
    // Fits iff every bit above the OUT sign bit replicates the sign.
    sat    = (r[RW-1:OUT_W-1] != {(RW-OUT_W+1){r[RW-1]}});
    result = r[OUT_W-1:0];
    if (sat) begin
      result = r[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sat_mult_pipe.sv
// Pipelined signed fixed-point multiplier with rounding, saturation and per-channel
// saturation statistics for time-multiplexed IIR coefficient products.
module sat_mult_pipe
  import sat_mult_pkg::*;
#(
  parameter int A_W         = 36,
  parameter int A_FL        = 27,
  parameter int B_W         = 15,
  parameter int B_FL        = 11,
  parameter int OUT_W       = 39,
  parameter int OUT_FL      = 29,
  parameter int ROUND_MODE  = 1,
  parameter int PIPE_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  sat_mult_pipe_if.slave    bus,
  input  logic              clr_stats,
  input  logic [CH_W-1:0]   stat_sel,
  output logic [CNT_W-1:0]  stat_cnt,
  output logic [NUM_CH-1:0] sat_sticky
);
  localparam int SH = A_FL + B_FL - OUT_FL;
  localparam int PW = A_W + B_W;

  if (SH < 0) begin : g_bad_sh
    $error("sat_mult_pipe: A_FL + B_FL - OUT_FL must be >= 0");
  end
  if (PIPE_STAGES < int'(PIPE_STAGES_MIN) || PIPE_STAGES > int'(PIPE_STAGES_MAX)) begin : g_bad_pipe
    $error("sat_mult_pipe: PIPE_STAGES must lie in 1..3");
  end

  logic                    s1_valid;
  logic signed [A_W-1:0]   s1_a;
  logic signed [B_W-1:0]   s1_b;
  logic [CH_W-1:0]         s1_ch;
  logic signed [PW-1:0]    prod;
  logic                    s2_valid;
  logic signed [PW-1:0]    s2_prod;
  logic [CH_W-1:0]         s2_ch;
  logic signed [OUT_W-1:0] rnd_data;
  logic                    rnd_sat;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_sat_q;

  if (PIPE_STAGES >= 3) begin : g_in_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_a     <= '0;
        s1_b     <= '0;
        s1_ch    <= '0;
      end else if (clk_enable) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a  <= bus.in_a;
          s1_b  <= bus.in_b;
          s1_ch <= bus.in_ch;
        end
      end
    end
  end else begin : g_in_pass
    assign s1_valid = bus.in_valid;
    assign s1_a     = bus.in_a;
    assign s1_b     = bus.in_b;
    assign s1_ch    = bus.in_ch;
  end

  assign prod = $signed({{B_W{s1_a[A_W-1]}}, s1_a}) * $signed({{A_W{s1_b[B_W-1]}}, s1_b});

  if (PIPE_STAGES >= 2) begin : g_prod_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_prod  <= '0;
        s2_ch    <= '0;
      end else if (clk_enable) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_prod <= prod;
          s2_ch   <= s1_ch;
        end
      end
    end
  end else begin : g_prod_pass
    assign s2_valid = s1_valid;
    assign s2_prod  = prod;
    assign s2_ch    = s1_ch;
  end

  sat_round #(
    .IN_W       (PW),
    .SH         (SH),
    .OUT_W      (OUT_W),
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .prod   (s2_prod),
    .result (rnd_data),
    .sat    (rnd_sat)
  );

  // Idle slots keep the last result on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
    end else if (clk_enable) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q <= rnd_data;
        out_ch_q   <= s2_ch;
        out_sat_q  <= rnd_sat;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sat   = out_sat_q;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  stat_cnt_q, stat_cnt_d;

  // A clear coinciding with a saturating result clears first, then counts it.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_stats) begin
      for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
      sticky_d = '0;
    end
    if (out_valid_q && out_sat_q && (int'(out_ch_q) < NUM_CH)) begin
      if (cnt_d[out_ch_q] != {CNT_W{1'b1}}) cnt_d[out_ch_q] = cnt_d[out_ch_q] + CNT_W'(1);
      sticky_d[out_ch_q] = 1'b1;
    end
    stat_cnt_d = (int'(stat_sel) < NUM_CH) ? cnt_q[stat_sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      sticky_q   <= '0;
      stat_cnt_q <= '0;
    end else if (clk_enable) begin
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt   = stat_cnt_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_sat_mult_pipe.sv
// Randomised scoreboard bench: three sat_mult_pipe variants (mode/latency/counter width)
// share one stimulus stream and are each checked against an arithmetic reference model.
module tb_sat_mult_pipe;

  localparam int     SH   = 27 + 11 - 29;
  localparam longint MAXV = (longint'(1) <<< 38) - 1;
  localparam longint MINV = -(longint'(1) <<< 38);

  typedef struct {
    logic signed [38:0] data;
    bit                 sat;
    int                 ch;
    int                 tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_enable = 1'b1;
  logic clr_stats = 1'b0;
  logic [1:0] stat_sel = '0;
  logic in_valid = 1'b0;
  logic signed [35:0] in_a = '0;
  logic signed [14:0] in_b = '0;
  logic [1:0] in_ch = '0;

  logic [15:0] stat_cnt0, stat_cnt2;
  logic [3:0]  stat_cnt1;
  logic [3:0]  sticky0, sticky1, sticky2;

  always #5 clk = ~clk;

  sat_mult_pipe_if if0 ();
  sat_mult_pipe_if if1 ();
  sat_mult_pipe_if if2 ();

  assign {if0.in_valid, if0.in_a, if0.in_b, if0.in_ch} = {in_valid, in_a, in_b, in_ch};
  assign {if1.in_valid, if1.in_a, if1.in_b, if1.in_ch} = {in_valid, in_a, in_b, in_ch};
  assign {if2.in_valid, if2.in_a, if2.in_b, if2.in_ch} = {in_valid, in_a, in_b, in_ch};

  sat_mult_pipe u0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if0), .clr_stats(clr_stats),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt0), .sat_sticky(sticky0)
  );
  sat_mult_pipe #(.ROUND_MODE(0), .PIPE_STAGES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if1), .clr_stats(clr_stats),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt1), .sat_sticky(sticky1)
  );
  sat_mult_pipe #(.ROUND_MODE(2), .PIPE_STAGES(3)) u2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(if2), .clr_stats(clr_stats),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt2), .sat_sticky(sticky2)
  );

  int mode_k[3] = '{1, 0, 2};
  int lat_k[3]  = '{2, 1, 3};
  int max_k[3]  = '{65535, 15, 65535};

  logic               ov[3];
  logic signed [38:0] od[3];
  logic [1:0]         och[3];
  logic               osat[3];
  int                 scnt[3];
  logic [3:0]         stk[3];

  assign ov[0] = if0.out_valid;  assign od[0] = if0.out_data;
  assign ov[1] = if1.out_valid;  assign od[1] = if1.out_data;
  assign ov[2] = if2.out_valid;  assign od[2] = if2.out_data;
  assign och[0] = if0.out_ch;    assign osat[0] = if0.out_sat;
  assign och[1] = if1.out_ch;    assign osat[1] = if1.out_sat;
  assign och[2] = if2.out_ch;    assign osat[2] = if2.out_sat;
  assign scnt[0] = int'(stat_cnt0);
  assign scnt[1] = int'(stat_cnt1);
  assign scnt[2] = int'(stat_cnt2);
  assign stk[0] = sticky0;  assign stk[1] = sticky1;  assign stk[2] = sticky2;

  int n_tests = 0;
  int n_fail = 0;
  int ecyc = 0;

  exp_t q0[$], q1[$], q2[$];
  int   mcnt[3][4];
  bit   msticky[3][4];
  bit   pend[3];
  bit   pend_sat[3];
  int   pend_ch[3];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact product, floor divide by 2^SH, round on the remainder, clamp.
  function automatic exp_t model(input longint a, input longint b, input int mode,
                                 input int ch, input int tag);
    exp_t e;
    longint p, t, rem, r;
    p   = a * b;
    t   = p >>> SH;
    rem = p - t * (longint'(1) <<< SH);
    r   = t;
    if (mode == 1 && rem >= (longint'(1) <<< (SH - 1))) r++;
    if (mode == 2 && (rem > (longint'(1) <<< (SH - 1)) ||
        (rem == (longint'(1) <<< (SH - 1)) && (t & 1) != 0))) r++;
    e.sat = 1'b0;
    if (r > MAXV) begin r = MAXV; e.sat = 1'b1; end
    else if (r < MINV) begin r = MINV; e.sat = 1'b1; end
    e.data = 39'(r);
    e.ch   = ch;
    e.tag  = tag;
    return e;
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    case (k)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_clear(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Monitor: pop on each fresh result, check frozen outputs while disabled, track stats.
  initial begin
    bit en_e, rst_e;
    logic               pv[3];
    logic signed [38:0] pd[3];
    logic [1:0]         pc[3];
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; msticky[k][c] = 1'b0; end
    end
    forever begin
      @(posedge clk);
      en_e  = clk_enable;
      rst_e = reset;
      if (clk_enable) ecyc++;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_e) begin
          chk($sformatf("dut%0d reset outputs", k), longint'({ov[k], od[k], och[k], osat[k]}), 0);
        end else if (!en_e) begin
          chk($sformatf("dut%0d frozen", k), longint'({ov[k], od[k], och[k]}),
              longint'({pv[k], pd[k], pc[k]}));
        end else if (ov[k]) begin
          if (sb_size(k) == 0) begin
            chk($sformatf("dut%0d unexpected out_valid", k), 1, 0);
          end else begin
            sb_pop(k, e);
            chk($sformatf("dut%0d data", k), longint'(od[k]), longint'(e.data));
            chk($sformatf("dut%0d sat", k), longint'(osat[k]), longint'(e.sat));
            chk($sformatf("dut%0d ch", k), longint'(och[k]), longint'(e.ch));
            chk($sformatf("dut%0d latency", k), ecyc - e.tag, lat_k[k]);
            pend[k] = 1'b1;
            pend_sat[k] = e.sat;
            pend_ch[k] = e.ch;
          end
        end
        pv[k] = ov[k];
        pd[k] = od[k];
        pc[k] = och[k];
        if (reset) begin
          for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; msticky[k][c] = 1'b0; end
          pend[k] = 1'b0;
          sb_clear(k);
        end else if (clk_enable) begin
          if (clr_stats)
            for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; msticky[k][c] = 1'b0; end
          if (pend[k] && pend_sat[k]) begin
            if (mcnt[k][pend_ch[k]] < max_k[k]) mcnt[k][pend_ch[k]]++;
            msticky[k][pend_ch[k]] = 1'b1;
          end
          pend[k] = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit v, input longint a, input longint b, input int ch,
                       input bit en, input bit clr);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_a       = 36'(a);
    in_b       = 15'(b);
    in_ch      = 2'(ch);
    clk_enable = en;
    clr_stats  = clr;
    if (v && en && !reset)
      for (int k = 0; k < 3; k++)
        sb_push(k, model(longint'(in_a), longint'(in_b), mode_k[k], ch, ecyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      stat_sel = 2'(c);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s dut%0d cnt[%0d]", tag, k, c), scnt[k], mcnt[k][c]);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s dut%0d sticky", tag, k), longint'(stk[k]),
          longint'({msticky[k][3], msticky[k][2], msticky[k][1], msticky[k][0]}));
  endtask

  localparam longint AMAX = (longint'(1) <<< 35) - 1;
  localparam longint BMAX = (longint'(1) <<< 14) - 1;

  initial begin
    logic signed [35:0] ra;
    logic signed [14:0] rb;
    bit en, v, clr;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_stats("reset");

    drive(1'b1, longint'(1) <<< 27, longint'(1) <<< 11, 2, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 1, 1'b1, 1'b0);
    drive(1'b1, -(AMAX + 1), BMAX, 1, 1'b1, 1'b0);
    drive(1'b1, 256, 1, 0, 1'b1, 1'b0);
    drive(1'b1, 768, 1, 0, 1'b1, 1'b0);
    drive(1'b1, -256, 1, 3, 1'b1, 1'b0);
    idle(6);
    check_stats("directed");

    drive(1'b0, 0, 0, 0, 1'b1, 1'b1);
    drive(1'b1, AMAX, BMAX, 0, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 3, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 0, 1'b1, 1'b0);
    idle(6);
    check_stats("b2b");
    for (int i = 0; i < 20; i++) drive(1'b1, -(AMAX + 1), BMAX, 0, 1'b1, 1'b0);
    idle(6);
    check_stats("cnt_hold");

    // Clear lands on a saturating ch1 result in every variant's output window.
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1);
    drive(1'b1, AMAX, BMAX, 1, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 1, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 1, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 1, 1'b1, 1'b1);
    idle(6);
    check_stats("clr_same");

    for (int i = 0; i < 300; i++) begin
      ra  = 36'({$urandom(), $urandom()});
      ra  = ra >>> $urandom_range(0, 35);
      rb  = 15'($urandom());
      rb  = rb >>> $urandom_range(0, 14);
      v   = ($urandom_range(0, 3) != 0);
      en  = !(i >= 100 && i < 103) && ($urandom_range(0, 6) != 0);
      clr = ($urandom_range(0, 49) == 0);
      drive(v, longint'(ra), longint'(rb), int'($urandom_range(0, 3)), en, clr);
    end
    idle(6);
    check_stats("random");

    drive(1'b1, AMAX, BMAX, 2, 1'b1, 1'b0);
    drive(1'b1, AMAX, BMAX, 3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    check_stats("midreset");

    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d drained", k), sb_size(k), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
